amns_operand_bank: RTL and testbench

AMNS_OPERAND_BANK -- requirements
Module: amns_operand_bank

---
 rtl/amns_pkg.sv | 17 +
 rtl/amns_word_shreg.sv | 45 ++++
 rtl/amns_operand_bank.sv | 252 +++++++++++++++++++++++++
 tb/tb_amns_operand_bank.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/amns_pkg.sv
// Shared AMNS operand-bank types: load-target select and coefficient word indexing.
package amns_pkg;

    typedef enum logic [1:0] {
        SEL_A   = 2'b00,
        SEL_B   = 2'b01,
        SEL_M   = 2'b10,
        SEL_MP0 = 2'b11
    } sel_e;

    // Flat word index of word j of coefficient i, with s words per coefficient
    function automatic int unsigned word_idx(input int unsigned i, input int unsigned j,
                                             input int unsigned s);
        return i * s + j;
    endfunction

endpackage

// File: rtl/amns_word_shreg.sv
// Word-granular shift register: serial load into the top word, right shift with
// rotate (word 0 re-enters at the top) or zero-fill.
module amns_word_shreg #(
    parameter int unsigned WORD_WIDTH = 17,
    parameter int unsigned DEPTH      = 20,
    parameter int unsigned ROTATE     = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        load_i,
    input  logic [WORD_WIDTH-1:0]       din_i,
    input  logic                        shift_i,
    output logic [DEPTH*WORD_WIDTH-1:0] q_o
);

    localparam int unsigned TOT = DEPTH * WORD_WIDTH;
    localparam int unsigned TOP = TOT - WORD_WIDTH;

    logic [TOT-1:0]        q_q;
    logic [TOT-1:0]        q_d;
    logic [WORD_WIDTH-1:0] top_c;

    // Load and shift are the same move; only the word entering the top differs
    always_comb begin
        top_c = (ROTATE != 0) ? q_q[WORD_WIDTH-1:0] : '0;
        if (load_i) begin
            top_c = din_i;
        end
        q_d = q_q;
        if (load_i || shift_i) begin
            q_d = (q_q >> WORD_WIDTH) | (TOT'(top_c) << TOP);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/amns_operand_bank.sv
// AMNS multiplier operand bank: double-buffered A/B, modulus M and M'0 registers
// loaded over a serial word stream, plus a parallel-in/serial-out result buffer.
module amns_operand_bank
    import amns_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 17,
    parameter int unsigned N          = 5,
    parameter int unsigned S          = 4,
    parameter int unsigned ROTATE     = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [1:0]                    in_sel_i,
    input  logic [WORD_WIDTH-1:0]         in_data_i,
    output logic                          op_valid_o,
    input  logic                          op_release_i,
    input  logic                          b_shift_i,
    input  logic                          m_shift_i,
    output logic [N*S*WORD_WIDTH-1:0]     a_dout_o,
    output logic [N*WORD_WIDTH-1:0]       b_dout_o,
    output logic [N*WORD_WIDTH-1:0]       m_dout_o,
    output logic [N*WORD_WIDTH-1:0]       mp0_dout_o,
    input  logic                          res_load_i,
    input  logic [N*WORD_WIDTH-1:0]       res_din_i,
    output logic                          res_valid_o,
    input  logic                          res_ready_i,
    output logic [WORD_WIDTH-1:0]         res_data_o,
    output logic                          err_o
);

    localparam int unsigned W     = WORD_WIDTH;
    localparam int unsigned WORDS = N * S;
    localparam int unsigned TOT   = WORDS * W;
    localparam int unsigned CW    = $clog2(WORDS + 1);
    localparam int unsigned LW    = $clog2(S + 1);

    // Load sequencing and bank bookkeeping
    logic          busy_q, busy_d;
    sel_e          sel_q, sel_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    a_full_q, a_full_d;
    logic [1:0]    b_full_q, b_full_d;
    logic          err_q, err_d;

    // Result buffer
    logic [TOT-1:0] res_q, res_d;
    logic           res_full_q, res_full_d;
    logic [LW-1:0]  res_lcnt_q, res_lcnt_d;
    logic [CW-1:0]  res_dcnt_q, res_dcnt_d;

    sel_e       sel_c;
    logic       ready_c;
    logic       op_valid_c;
    logic       xfer_c;
    logic       last_c;
    logic       rel_c;
    logic       done_c;
    logic       other_free_c;
    logic       res_wr_c;
    logic       res_pop_c;
    logic [1:0] a_load_c;
    logic [1:0] b_load_c;
    logic [1:0] b_shift_c;

    logic [TOT-1:0]   a_bank [2];
    logic [TOT-1:0]   b_bank [2];
    logic [TOT-1:0]   m_word;
    logic [N*W-1:0]   mp0_word;

    // Target is taken from the port only on the first word of a load
    assign sel_c      = busy_q ? sel_q : sel_e'(in_sel_i);
    assign op_valid_c = a_full_q[rd_ptr_q] & b_full_q[rd_ptr_q];

    always_comb begin
        ready_c = 1'b0;
        case (sel_c)
            SEL_A:   ready_c = !a_full_q[wr_ptr_q];
            SEL_B:   ready_c = !b_full_q[wr_ptr_q];
            default: ready_c = !op_valid_c;
        endcase
    end

    assign in_ready_o  = ready_c & ~reset;
    assign op_valid_o  = op_valid_c & ~reset;
    assign res_valid_o = res_full_q & ~reset;

    assign xfer_c    = in_valid_i & in_ready_o;
    assign last_c    = (sel_c == SEL_MP0) ? (wcnt_q == CW'(N - 1)) : (wcnt_q == CW'(WORDS - 1));
    assign done_c    = xfer_c & last_c;
    assign rel_c     = op_release_i & op_valid_o;
    assign res_wr_c  = res_load_i & ~res_full_q;
    assign res_pop_c = res_valid_o & res_ready_i;

    always_comb begin
        a_load_c  = '0;
        b_load_c  = '0;
        b_shift_c = '0;
        a_load_c[wr_ptr_q]  = xfer_c && (sel_c == SEL_A);
        b_load_c[wr_ptr_q]  = xfer_c && (sel_c == SEL_B);
        b_shift_c[rd_ptr_q] = b_shift_i && op_valid_c;
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        amns_word_shreg #(.WORD_WIDTH(W), .DEPTH(WORDS), .ROTATE(ROTATE)) u_a (
            .clock   (clock),
            .reset   (reset),
            .load_i  (a_load_c[g]),
            .din_i   (in_data_i),
            .shift_i (1'b0),
            .q_o     (a_bank[g])
        );
        amns_word_shreg #(.WORD_WIDTH(W), .DEPTH(WORDS), .ROTATE(ROTATE)) u_b (
            .clock   (clock),
            .reset   (reset),
            .load_i  (b_load_c[g]),
            .din_i   (in_data_i),
            .shift_i (b_shift_c[g]),
            .q_o     (b_bank[g])
        );
    end

    amns_word_shreg #(.WORD_WIDTH(W), .DEPTH(WORDS), .ROTATE(ROTATE)) u_m (
        .clock   (clock),
        .reset   (reset),
        .load_i  (xfer_c && (sel_c == SEL_M)),
        .din_i   (in_data_i),
        .shift_i (m_shift_i),
        .q_o     (m_word)
    );

    amns_word_shreg #(.WORD_WIDTH(W), .DEPTH(N), .ROTATE(ROTATE)) u_mp0 (
        .clock   (clock),
        .reset   (reset),
        .load_i  (xfer_c && (sel_c == SEL_MP0)),
        .din_i   (in_data_i),
        .shift_i (1'b0),
        .q_o     (mp0_word)
    );

    always_comb begin
        busy_d   = busy_q;
        sel_d    = sel_q;
        wcnt_d   = wcnt_q;
        a_full_d = a_full_q;
        b_full_d = b_full_q;
        rd_ptr_d = rd_ptr_q ^ rel_c;
        err_d    = err_q | (op_release_i & ~op_valid_c) | (res_load_i & res_full_q);

        if (xfer_c) begin
            sel_d = sel_c;
            if (last_c) begin
                busy_d = 1'b0;
                wcnt_d = '0;
            end else begin
                busy_d = 1'b1;
                wcnt_d = wcnt_q + CW'(1);
            end
        end

        if (rel_c) begin
            a_full_d[rd_ptr_q] = 1'b0;
            b_full_d[rd_ptr_q] = 1'b0;
        end
        if (done_c && (sel_c == SEL_A)) begin
            a_full_d[wr_ptr_q] = 1'b1;
        end
        if (done_c && (sel_c == SEL_B)) begin
            b_full_d[wr_ptr_q] = 1'b1;
        end

        // Only move the write pointer onto a bank that is (or is being made) free
        other_free_c = !(a_full_q[!wr_ptr_q] & b_full_q[!wr_ptr_q])
                       || (rel_c && (rd_ptr_q != wr_ptr_q));
        wr_ptr_d = wr_ptr_q ^ (a_full_q[wr_ptr_q] & b_full_q[wr_ptr_q] & other_free_c);
    end

    // Result buffer: column-wise parallel fill, then drain from index 0 upwards
    always_comb begin
        res_d      = res_q;
        res_full_d = res_full_q;
        res_lcnt_d = res_lcnt_q;
        res_dcnt_d = res_dcnt_q;
        if (res_wr_c) begin
            for (int unsigned i = 0; i < N; i++) begin
                res_d[word_idx(i, 32'(res_lcnt_q), S)*W +: W] = res_din_i[i*W +: W];
            end
            if (res_lcnt_q == LW'(S - 1)) begin
                res_full_d = 1'b1;
                res_lcnt_d = '0;
            end else begin
                res_lcnt_d = res_lcnt_q + LW'(1);
            end
        end else if (res_pop_c) begin
            res_d = res_q >> W;
            if (res_dcnt_q == CW'(WORDS - 1)) begin
                res_full_d = 1'b0;
                res_dcnt_d = '0;
            end else begin
                res_dcnt_d = res_dcnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q     <= 1'b0;
            sel_q      <= SEL_A;
            wcnt_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            a_full_q   <= '0;
            b_full_q   <= '0;
            err_q      <= 1'b0;
            res_q      <= '0;
            res_full_q <= 1'b0;
            res_lcnt_q <= '0;
            res_dcnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            sel_q      <= sel_d;
            wcnt_q     <= wcnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            a_full_q   <= a_full_d;
            b_full_q   <= b_full_d;
            err_q      <= err_d;
            res_q      <= res_d;
            res_full_q <= res_full_d;
            res_lcnt_q <= res_lcnt_d;
            res_dcnt_q <= res_dcnt_d;
        end
    end

    always_comb begin
        a_dout_o = a_bank[rd_ptr_q];
        b_dout_o = '0;
        m_dout_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            b_dout_o[i*W +: W] = b_bank[rd_ptr_q][word_idx(i, 0, S)*W +: W];
            m_dout_o[i*W +: W] = m_word[word_idx(i, 0, S)*W +: W];
        end
    end

    assign mp0_dout_o = mp0_word;
    assign res_data_o = res_q[W-1:0];
    assign err_o      = err_q;

endmodule

// File: tb/tb_amns_operand_bank.sv
// Randomised self-checking bench for amns_operand_bank against a stream-level model.
module tb_amns_operand_bank;

    localparam int unsigned W     = 17;
    localparam int unsigned N     = 5;
    localparam int unsigned S     = 4;
    localparam int unsigned WORDS = N * S;
    localparam int unsigned CHKW  = WORDS * W;

    logic               clock;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_sel;
    logic [W-1:0]       in_data;
    logic               op_valid;
    logic               op_release;
    logic               b_shift;
    logic               m_shift;
    logic [CHKW-1:0]    a_dout;
    logic [N*W-1:0]     b_dout;
    logic [N*W-1:0]     m_dout;
    logic [N*W-1:0]     mp0_dout;
    logic               res_load;
    logic [N*W-1:0]     res_din;
    logic               res_valid;
    logic               res_ready;
    logic [W-1:0]       res_data;
    logic               err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] a1 [WORDS];
    logic [W-1:0] b1 [WORDS];
    logic [W-1:0] a2 [WORDS];
    logic [W-1:0] b2 [WORDS];
    logic [W-1:0] a3 [WORDS];
    logic [W-1:0] b3 [WORDS];
    logic [W-1:0] mm [WORDS];
    logic [W-1:0] mp [WORDS];

    amns_operand_bank #(.WORD_WIDTH(W), .N(N), .S(S), .ROTATE(1)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_sel_i     (in_sel),
        .in_data_i    (in_data),
        .op_valid_o   (op_valid),
        .op_release_i (op_release),
        .b_shift_i    (b_shift),
        .m_shift_i    (m_shift),
        .a_dout_o     (a_dout),
        .b_dout_o     (b_dout),
        .m_dout_o     (m_dout),
        .mp0_dout_o   (mp0_dout),
        .res_load_i   (res_load),
        .res_din_i    (res_din),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_data_o   (res_data),
        .err_o        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [CHKW-1:0] got, input logic [CHKW-1:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word k of a stream lands at index k
    function automatic logic [CHKW-1:0] pack_all(input logic [W-1:0] w [WORDS], input int cnt);
        logic [CHKW-1:0] r;
        r = '0;
        for (int k = 0; k < cnt; k++) r[k*W +: W] = w[k];
        return r;
    endfunction

    // Coefficient-slot view after k one-word right rotations
    function automatic logic [CHKW-1:0] pack_slots(input logic [W-1:0] w [WORDS], input int k);
        logic [CHKW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = w[(i*S + k) % WORDS];
        return r;
    endfunction

    function automatic logic [W-1:0] res_word(input int k);
        return W'(32'h100 * (k / S) + (k % S));
    endfunction

    task automatic push(input logic [1:0] sel, input logic [W-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        #1;
        while (!in_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (!in_ready) check("push_timeout", CHKW'(in_ready), CHKW'(1));
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic push_stream(input logic [1:0] sel, input logic [W-1:0] w [WORDS],
                               input int first, input int last);
        for (int k = first; k <= last; k++) push(sel, w[k]);
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    initial begin
        for (int k = 0; k < WORDS; k++) begin
            a1[k] = W'($urandom); b1[k] = W'($urandom);
            a2[k] = W'($urandom); b2[k] = W'($urandom);
            a3[k] = W'($urandom); b3[k] = W'($urandom);
            mm[k] = W'($urandom); mp[k] = W'($urandom);
        end
        reset = 1'b1; in_valid = 1'b0; in_sel = 2'b00; in_data = '0;
        op_release = 1'b0; b_shift = 1'b0; m_shift = 1'b0;
        res_load = 1'b0; res_din = '0; res_ready = 1'b0;

        // Reset state
        #1;
        check("rst_in_ready", CHKW'(in_ready), CHKW'(0));
        check("rst_op_valid", CHKW'(op_valid), CHKW'(0));
        check("rst_res_valid", CHKW'(res_valid), CHKW'(0));
        tick();
        check("rst_a_dout", a_dout, '0);
        check("rst_err", CHKW'(err), CHKW'(0));
        tick();
        reset = 1'b0;

        // First operand pair into bank 0
        push_stream(2'b00, a1, 0, WORDS - 1);
        push_stream(2'b01, b1, 0, WORDS - 2);
        check("op_valid_before_last_b", CHKW'(op_valid), CHKW'(0));
        push(2'b01, b1[WORDS-1]);
        check("op_valid_after_last_b", CHKW'(op_valid), CHKW'(1));
        check("a_dout_pair1", a_dout, pack_all(a1, WORDS));
        check("b_dout_pair1", CHKW'(b_dout), pack_slots(b1, 0));
        in_sel = 2'b10;
        #1;
        check("m_ready_while_op_valid", CHKW'(in_ready), CHKW'(0));

        // B rotation through a full cycle
        b_shift = 1'b1;
        for (int k = 1; k <= WORDS; k++) begin
            tick();
            check($sformatf("b_shift_%0d", k), CHKW'(b_dout), pack_slots(b1, k));
        end
        b_shift = 1'b0;

        // Second pair fills bank 1, a third A must stall
        push_stream(2'b00, a2, 0, WORDS - 1);
        push_stream(2'b01, b2, 0, WORDS - 1);
        in_sel = 2'b00;
        tick(); tick();
        check("third_a_stalled", CHKW'(in_ready), CHKW'(0));
        check("a_dout_still_pair1", a_dout, pack_all(a1, WORDS));

        op_release = 1'b1;
        tick();
        op_release = 1'b0;
        #1;
        check("ready_after_release", CHKW'(in_ready), CHKW'(1));
        check("op_valid_bank1", CHKW'(op_valid), CHKW'(1));
        check("a_dout_pair2", a_dout, pack_all(a2, WORDS));
        check("b_dout_pair2", CHKW'(b_dout), pack_slots(b2, 0));
        op_release = 1'b1;
        tick();
        op_release = 1'b0;
        check("op_valid_drained", CHKW'(op_valid), CHKW'(0));
        check("err_clean", CHKW'(err), CHKW'(0));

        // Release with nothing to release
        op_release = 1'b1;
        tick();
        op_release = 1'b0;
        in_sel = 2'b00;
        #1;
        check("err_bad_release", CHKW'(err), CHKW'(1));
        check("op_valid_bad_release", CHKW'(op_valid), CHKW'(0));
        check("ready_bad_release", CHKW'(in_ready), CHKW'(1));

        // M load and rotation, M'0 load
        push_stream(2'b10, mm, 0, WORDS - 1);
        check("m_dout_loaded", CHKW'(m_dout), pack_slots(mm, 0));
        m_shift = 1'b1;
        for (int k = 1; k <= 7; k++) tick();
        m_shift = 1'b0;
        check("m_dout_shift7", CHKW'(m_dout), pack_slots(mm, 7));
        push_stream(2'b11, mp, 0, N - 1);
        check("mp0_dout", CHKW'(mp0_dout), pack_all(mp, N));

        // Reset in the middle of an A load
        push_stream(2'b00, a3, 0, 6);
        reset = 1'b1;
        #1;
        check("midrst_in_ready", CHKW'(in_ready), CHKW'(0));
        check("midrst_op_valid", CHKW'(op_valid), CHKW'(0));
        tick();
        check("midrst_a_dout", a_dout, '0);
        check("midrst_m_dout", CHKW'(m_dout), '0);
        check("midrst_mp0_dout", CHKW'(mp0_dout), '0);
        check("midrst_err", CHKW'(err), CHKW'(0));
        reset = 1'b0;
        push_stream(2'b00, a3, 0, WORDS - 1);
        push_stream(2'b01, b3, 0, WORDS - 1);
        check("op_valid_after_rst", CHKW'(op_valid), CHKW'(1));
        check("a_dout_after_rst", a_dout, pack_all(a3, WORDS));

        // RES fill and drain, with an illegal load mid-drain
        for (int j = 0; j < S; j++) begin
            for (int i = 0; i < N; i++) res_din[i*W +: W] = W'(32'h100 * i + j);
            res_load = 1'b1;
            tick();
            res_load = 1'b0;
            check($sformatf("res_valid_load%0d", j), CHKW'(res_valid), CHKW'(j == S - 1));
        end
        check("err_before_res", CHKW'(err), CHKW'(0));
        res_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("res_word_%0d", k), CHKW'(res_data), CHKW'(res_word(k)));
            tick();
        end
        res_ready = 1'b0;
        for (int i = 0; i < N; i++) res_din[i*W +: W] = W'($urandom);
        res_load = 1'b1;
        tick();
        res_load = 1'b0;
        check("err_res_load_drain", CHKW'(err), CHKW'(1));
        check("res_valid_held", CHKW'(res_valid), CHKW'(1));
        res_ready = 1'b1;
        for (int k = 3; k < WORDS; k++) begin
            check($sformatf("res_word_%0d", k), CHKW'(res_data), CHKW'(res_word(k)));
            tick();
        end
        res_ready = 1'b0;
        check("res_valid_empty", CHKW'(res_valid), CHKW'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
